// File: rtl/fifo_word_uart_tx_if.sv
// Handshake bundle between the word FIFO read port and the UART TX serializer.
// master = serializer side, slave = FIFO / board side.
interface fifo_word_uart_tx_if #(
  parameter int BIT_DEPTH = 32
);
  logic                 fifo_empty;
  logic [BIT_DEPTH-1:0] value_to_read;
  logic                 enable_read;
  logic                 tx;
  logic                 busy;
  logic                 word_done;

  modport master (
    input  fifo_empty,
    input  value_to_read,
    output enable_read,
    output tx,
    output busy,
    output word_done
  );

  modport slave (
    output fifo_empty,
    output value_to_read,
    input  enable_read,
    input  tx,
    input  busy,
    input  word_done
  );
endinterface

// File: rtl/fifo_word_uart_tx.sv
// Pops FIFO words and sends them LSB byte first as back-to-back 8N1 UART frames.
// Optional even parity bit per byte when UART_PARITY_EN is defined (8E1).
module fifo_word_uart_tx #(
  parameter int BIT_DEPTH      = 32,
  parameter int BYTES_PER_WORD = 4,
  parameter int CLKS_PER_BIT   = 868
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_word_uart_tx_if.master   bus
);
  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam int                BYTE_W    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_WORD - 1);

  generate
    if (BIT_DEPTH != 8 * BYTES_PER_WORD) begin : g_bad_width
      $error("BIT_DEPTH must equal 8*BYTES_PER_WORD");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            bit_idx_q;
  logic [BYTE_W-1:0]     byte_idx_q;
  logic [BIT_DEPTH-1:0]  word_q;
  logic                  par_q;
  logic                  tx_q;
  logic                  enable_read_q;
  logic                  busy_q;
  logic                  word_done_q;
  logic                  bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      byte_idx_q    <= '0;
      par_q         <= 1'b0;
      tx_q          <= 1'b1;
      enable_read_q <= 1'b0;
      busy_q        <= 1'b0;
      word_done_q   <= 1'b0;
    end else begin
      enable_read_q <= 1'b0;
      word_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!bus.fifo_empty) begin
            state_q       <= POP;
            enable_read_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        POP: state_q <= LOAD;
        LOAD: begin
          byte_idx_q <= '0;
          cnt_q      <= '0;
          tx_q       <= 1'b0;
          state_q    <= START;
        end
        START: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= word_q[0];
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            par_q <= par_q ^ word_q[0];
            if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_q    <= par_q ^ word_q[0];
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              // word_q shifts on this same edge, so bit [1] is the next bit out
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= word_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (byte_idx_q != BYTE_LAST) begin
              byte_idx_q <= byte_idx_q + BYTE_W'(1);
              tx_q       <= 1'b0;
              state_q    <= START;
            end else begin
              byte_idx_q  <= '0;
              word_done_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Bytes go out LSB first and bits LSB first, so the whole word is one right-shift stream.
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      word_q <= bus.value_to_read;
    end else if (state_q == DATA && bit_end) begin
      word_q <= word_q >> 1;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.enable_read = enable_read_q;
  assign bus.busy        = busy_q;
  assign bus.word_done   = word_done_q;
endmodule

// File: tb/tb_fifo_word_uart_tx.sv
// Scoreboard bench for fifo_word_uart_tx: a FIFO model feeds words, a UART receiver monitor decodes tx.
module tb_fifo_word_uart_tx;
  localparam int BD  = 32;
  localparam int BPW = 4;
  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_word_uart_tx_if #(.BIT_DEPTH(BD)) bus ();

  fifo_word_uart_tx #(
    .BIT_DEPTH(BD),
    .BYTES_PER_WORD(BPW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] d;
    int         gap;
  } exp_t;

  exp_t        exp_q[$];
  logic [BD-1:0] fifo_q[$];
  logic        force_empty = 1'b0;
  int          n_total = 0;
  int          n_pass  = 0;
  int          cyc     = 0;
  int          er_cnt  = 0;
  int          wd_cnt  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic upd_empty();
    bus.fifo_empty = force_empty || (fifo_q.size() == 0);
  endtask

  // gap < 0 means the idle time before this byte is not checked
  task automatic exp4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input int first_gap);
    exp_q.push_back('{d: b0, gap: first_gap});
    exp_q.push_back('{d: b1, gap: 0});
    exp_q.push_back('{d: b2, gap: 0});
    exp_q.push_back('{d: b3, gap: 0});
  endtask

  task automatic wait_wd(input int target, input int budget);
    int n;
    n = 0;
    while (wd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("word_done_count", wd_cnt, target);
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (bus.tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", bus.tx, 0);
  endtask

  // FIFO read port: data appears the cycle after the pop strobe
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.enable_read) begin
        @(posedge clk);
        #1;
        if (fifo_q.size() > 0) bus.value_to_read = fifo_q.pop_front();
        upd_empty();
      end
    end
  end

  // UART receiver + strobe monitor, samples on the falling edge
  initial begin : mon
    int         pos, idle_run, gap, word_start, b;
    logic [7:0] data;
    logic       bitval, stop_b, par_b;
    bit         stab_err, in_frame;
    exp_t       e;
    pos = 0; idle_run = 999; gap = 0; word_start = 0; b = 0;
    data = '0; bitval = 1'b1; stop_b = 1'b0; par_b = 1'b0;
    stab_err = 1'b0; in_frame = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_frame = 1'b0;
        idle_run = 999;
      end else begin
        if (bus.enable_read) er_cnt++;
        if (bus.word_done) begin
          wd_cnt++;
          chk("word_done_latency", cyc - word_start, NB * CPB * BPW);
        end
        if (!in_frame && bus.tx == 1'b0) begin
          in_frame = 1'b1;
          pos      = 0;
          gap      = idle_run;
          if (gap != 0) word_start = cyc;
          stab_err = 1'b0;
          data     = '0;
        end
        if (!in_frame) begin
          idle_run++;
        end else begin
          if (pos % CPB == 0) bitval = bus.tx;
          else if (bus.tx !== bitval) stab_err = 1'b1;
          if (pos % CPB == CPB - 1) begin
            b = pos / CPB;
            if (b >= 1 && b <= 8) data[b-1] = bitval;
            else if (b == NB - 1) stop_b = bitval;
            else if (b == 9) par_b = bitval;
          end
          pos++;
          if (pos == NB * CPB) begin
            in_frame = 1'b0;
            idle_run = 0;
            if (exp_q.size() == 0) begin
              chk("unexpected_byte", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              chk("byte", data, e.d);
              chk("stop_bit", stop_b, 1);
              chk("bit_width", stab_err, 0);
              if (e.gap >= 0) chk("gap", gap, e.gap);
`ifdef UART_PARITY_EN
              chk("parity", par_b, ^e.d);
`endif
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, w0;
    bus.fifo_empty    = 1'b1;
    bus.value_to_read = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_enable_read", bus.enable_read, 0);
    chk("rst_word_done", bus.word_done, 0);
    rst_n = 1'b1;

    // Reset in the middle of DATA aborts the word at once
    fifo_q.push_back(32'h1234_5678);
    upd_empty();
    wait_start(50);
    repeat (12) @(negedge clk);
    chk("mid_frame_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", bus.tx, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_enable_read", bus.enable_read, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = er_cnt;
    repeat (100) @(negedge clk);
    chk("empty_no_pop", er_cnt - e0, 0);
    chk("empty_busy", bus.busy, 0);
    chk("empty_tx", bus.tx, 1);

    // Single word
    e0 = er_cnt; w0 = wd_cnt;
    exp4(8'h01, 8'h0F, 8'h5A, 8'hA5, -1);
    fifo_q.push_back(32'hA55A_0F01);
    upd_empty();
    wait_wd(w0 + 1, 2000);
    repeat (5) @(negedge clk);
    chk("single_pops", er_cnt - e0, 1);
    chk("single_word_done", wd_cnt - w0, 1);
    chk("single_drained", exp_q.size(), 0);

    // Three words back to back, 3-cycle idle between words
    e0 = er_cnt; w0 = wd_cnt;
    exp4(8'h01, 8'h00, 8'h00, 8'h00, -1);
    exp4(8'hFF, 8'hFF, 8'hFF, 8'hFF, 3);
    exp4(8'h00, 8'h00, 8'h00, 8'h80, 3);
    fifo_q.push_back(32'h0000_0001);
    fifo_q.push_back(32'hFFFF_FFFF);
    fifo_q.push_back(32'h8000_0000);
    upd_empty();
    wait_wd(w0 + 3, 4000);
    repeat (5) @(negedge clk);
    chk("b2b_pops", er_cnt - e0, 3);
    chk("b2b_word_done", wd_cnt - w0, 3);
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_idle_busy", bus.busy, 0);

    // FIFO reports empty while byte 1 is in DATA: word finishes, no further pop
    e0 = er_cnt; w0 = wd_cnt;
    exp4(8'h3C, 8'h3C, 8'hC3, 8'hC3, -1);
    exp4(8'h04, 8'h03, 8'h02, 8'h01, -1);
    fifo_q.push_back(32'hC3C3_3C3C);
    fifo_q.push_back(32'h0102_0304);
    upd_empty();
    wait_start(50);
    repeat (50) @(negedge clk);
    force_empty = 1'b1;
    upd_empty();
    wait_wd(w0 + 1, 2000);
    repeat (100) @(negedge clk);
    chk("hold_pops", er_cnt - e0, 1);
    chk("hold_word_done", wd_cnt - w0, 1);
    chk("hold_busy", bus.busy, 0);
    chk("hold_fifo_left", fifo_q.size(), 1);
    force_empty = 1'b0;
    upd_empty();
    wait_wd(w0 + 2, 2000);
    repeat (5) @(negedge clk);
    chk("resume_pops", er_cnt - e0, 2);
    chk("resume_drained", exp_q.size(), 0);

`ifdef UART_PARITY_EN
    // Parity bits for bytes 03,07,00,00 are 0,1,0,0
    w0 = wd_cnt;
    exp4(8'h03, 8'h07, 8'h00, 8'h00, -1);
    fifo_q.push_back(32'h0000_0703);
    upd_empty();
    wait_wd(w0 + 1, 2000);
    repeat (5) @(negedge clk);
    chk("parity_drained", exp_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
